rnd_sample_buffer: RTL and testbench
====================================

# rnd_sample_buffer

Consumer-side front end for the RandomGenerator block: seeds it, pulls samples with `out_gen_enable`, range-checks each sample against `[in_min, in_max]`, and buffers accepted samples in a small FIFO. Downstream MCMC proposal logic reads the FIFO over a valid/ready handshake. It is the reader end of the generator's enable/`out_rnd` interface and keeps the generator idle whenever the buffer cannot accept a sample.

## Interface
- `WIDTH`, 8: sample width; samples, `in_min` and `in_max` are signed two's complement.
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `SEED_CYCLES`, 2: cycles `out_gen_reset` is held during seeding.
- `in_clock`  in  1  single clock, rising edge.
- `in_reset`  in  1  synchronous, active-high reset.
- `in_start`  in  1  one-cycle pulse; begins a seed+run session (used only in IDLE).
- `in_stop`  in  1  one-cycle pulse; ends the run (used only in RUN).
- `in_seed`  in  WIDTH  seed forwarded to the generator.
- `in_min`, `in_max`  in  WIDTH  signed acceptance range, inclusive; sampled at `in_start`.
- `out_gen_reset`  out  1  drives generator `in_reset`.
- `out_gen_enable`  out  1  drives generator `in_enable`.
- `out_gen_seed`  out  WIDTH  drives generator `in_seed`.
- `in_rnd`  in  WIDTH  generator `out_rnd`.
- `out_valid`  out  1  FIFO head is valid.
- `out_data`  out  WIDTH  FIFO head sample.
- `in_ready`  in  1  downstream accepts head when `out_valid` is also high.
- `out_busy`  out  1  state ≠ IDLE.
- `out_cfg_error`  out  1  sticky; set if `in_min > in_max` at start.
- `out_reject_count`  out  8  saturating count of out-of-range samples.

## Operation
- FSM states:
  - IDLE: on `in_start`, latch min/max/seed. If min > max (signed), set `out_cfg_error` and stay in IDLE. Otherwise clear `out_cfg_error`, clear the reject count, and go to SEED.
  - SEED: `out_gen_reset`=1 for exactly `SEED_CYCLES` cycles (cycle counter), then go to RUN.
  - RUN: issue enables. On `in_stop`, go to DRAIN.
  - DRAIN: wait until no capture is pending (at most 1 cycle), then go to IDLE.
- `out_gen_seed` holds the latched seed from `in_start` until the next accepted `in_start`.
- `out_gen_enable` = RUN and !`in_stop` and (count + pending) < DEPTH, where pending = capture flag set by the previous cycle's enable.
- Capture: in the cycle after an enable cycle, `in_rnd` is the new sample.
  - If min ≤ `in_rnd` ≤ max (signed compare, WIDTH bits), push it.
  - Otherwise drop it and increment the reject count, saturating at 255.
- The FIFO is circular with wrap-around pointers and a count register sized 0..DEPTH.
- Pop when `out_valid` and `in_ready`. A simultaneous push and pop leaves the count unchanged.
- Overflow cannot occur by construction; a push while full is an assertion failure.
- The FIFO is not flushed by stop; entries stay readable in IDLE. A new `in_start` does not flush the FIFO either.
- `in_start` outside IDLE and `in_stop` outside RUN are ignored.

## Timing
- Reset: state IDLE, count=0, pointers=0, pending=0. All outputs are 0: `out_valid`, `out_data`, `out_gen_*`, `out_busy`, `out_cfg_error`, `out_reject_count`.
- Reset mid-operation aborts immediately: the FIFO is emptied and the generator is no longer enabled.
- `in_start` at edge t: `out_gen_reset` is high for cycles t+1..t+`SEED_CYCLES`, and RUN begins at t+`SEED_CYCLES`+1.
- Enable high in cycle n: the sample is captured at the end of cycle n+1 and `out_valid` is visible in cycle n+2.
- Latency from enable to `out_valid` is 2 cycles.
- Steady-state throughput is 1 sample per cycle while the FIFO is not full and `in_ready`=1.
- `out_data` is a registered memory read of the head; it is stable while `out_valid`=1 and no pop occurs.

## Structure
- Shared package `rnd_pkg`: FSM state enum (IDLE, SEED, RUN, DRAIN) and the `WIDTH` default. The generator and this block share the same `WIDTH` default.
- One sub-module, `rnd_fifo`: synchronous FIFO with push, pop, full, empty and count, parameterised by `WIDTH` and `DEPTH`.
- FSM, range check and reject counter live in the top module.

## Test plan
- Range [-20, 2], seed 2, `in_ready`=1:
  - RUN starts 3 cycles after start.
  - Every `out_data` lies in [-20, 2].
  - Accepted plus rejected equals the number of enable cycles.
- Backpressure with `in_ready`=0 and `DEPTH`=4:
  - Exactly 4 samples are buffered, after which `out_gen_enable` stays 0.
  - Raising `in_ready` for one cycle pops one entry and produces exactly one further enable.
- Range [20, 26]: `out_reject_count` saturates at 255 and never wraps to 0.
- min=5, max=-5 at start: `out_cfg_error`=1, `out_busy`=0, and `out_gen_reset` never rises.
- `in_stop` in the same cycle as an enable:
  - The pending sample is still captured.
  - DRAIN lasts 1 cycle, then IDLE.
  - Buffered entries remain readable afterwards.
- `in_reset` asserted mid-RUN with 3 entries buffered: the next cycle shows `out_valid`=0, count 0, IDLE, and all outputs 0.

Source files
------------

// File: rtl/rnd_pkg.sv
// rnd_pkg: shared definitions for the random-sample consumer path.
//   RND_WIDTH   - default sample width, shared with the generator block
//   rnd_state_e - sequencing states of rnd_sample_buffer
package rnd_pkg;

    localparam int RND_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SEED  = 2'd1,
        ST_RUN   = 2'd2,
        ST_DRAIN = 2'd3
    } rnd_state_e;

endpackage

// File: rtl/rnd_fifo.sv
// rnd_fifo: circular synchronous FIFO with a registered head read.
//   clk_i, rst_i     - clock, synchronous active-high reset
//   push_i, wdata_i  - write request and data (caller never pushes when full)
//   pop_i            - remove head; ignored while empty
//   rdata_o          - registered head entry, stable until the next pop
//   full_o, empty_o  - occupancy flags
//   count_o          - occupancy, 0..DEPTH
module rnd_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   push_i,
    input  logic [WIDTH-1:0]       wdata_i,
    input  logic                   pop_i,
    output logic [WIDTH-1:0]       rdata_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int              AW       = $clog2(DEPTH);
    localparam logic [AW-1:0]   PTR_ONE  = AW'(1);
    localparam logic [AW:0]     CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]     CNT_FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic             do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_FULL);
    assign count_o = count_q;
    assign rdata_o = head_q;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = push_i ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d = do_pop ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        count_d  = count_q;
        if (push_i && !do_pop)
            count_d = count_q + CNT_ONE;
        else if (!push_i && do_pop)
            count_d = count_q - CNT_ONE;
        // The head register looks one cycle ahead: if the slot that becomes
        // the head is being written right now, forward the write data.
        head_d = (push_i && (wr_ptr_q == rd_ptr_d)) ? wdata_i : mem_q[rd_ptr_d];
    end

    always_ff @(posedge clk_i) begin
        if (push_i)
            mem_q[wr_ptr_q] <= wdata_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
        end
    end

endmodule

// File: rtl/rnd_sample_buffer.sv
// rnd_sample_buffer: seeds the random generator, pulls samples with an
// enable, keeps the ones inside [min, max] (signed, inclusive) and buffers
// them for a valid/ready consumer.
//   in_clock, in_reset           - clock, synchronous active-high reset
//   in_start, in_stop            - session control pulses
//   in_seed, in_min, in_max      - session configuration, latched on start
//   out_gen_reset/enable/seed    - generator control
//   in_rnd                       - generator sample, valid the cycle after enable
//   out_valid, out_data, in_ready- downstream handshake on the FIFO head
//   out_busy                     - session in progress
//   out_cfg_error                - last start had min > max
//   out_reject_count             - saturating count of out-of-range samples
module rnd_sample_buffer
    import rnd_pkg::*;
#(
    parameter int WIDTH       = RND_WIDTH,
    parameter int DEPTH       = 4,
    parameter int SEED_CYCLES = 2
) (
    input  logic             in_clock,
    input  logic             in_reset,
    input  logic             in_start,
    input  logic             in_stop,
    input  logic [WIDTH-1:0] in_seed,
    input  logic [WIDTH-1:0] in_min,
    input  logic [WIDTH-1:0] in_max,
    output logic             out_gen_reset,
    output logic             out_gen_enable,
    output logic [WIDTH-1:0] out_gen_seed,
    input  logic [WIDTH-1:0] in_rnd,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             in_ready,
    output logic             out_busy,
    output logic             out_cfg_error,
    output logic [7:0]       out_reject_count
);

    localparam int              AW        = $clog2(DEPTH);
    localparam int              CW        = (SEED_CYCLES > 1) ? $clog2(SEED_CYCLES) : 1;
    localparam logic [CW-1:0]   SEED_LAST = CW'(SEED_CYCLES - 1);
    localparam logic [AW+1:0]   OCC_LIMIT = (AW+2)'(DEPTH);

    rnd_state_e       state_q, state_d;
    logic [CW-1:0]    seed_cnt_q, seed_cnt_d;
    logic [WIDTH-1:0] min_q, min_d, max_q, max_d, seed_q, seed_d;
    logic             cfg_err_q, cfg_err_d;
    logic [7:0]       rej_q, rej_d;
    logic             pend_q;

    logic             in_range, push, reject, pop;
    logic             fifo_full, fifo_empty;
    logic [AW:0]      fifo_count;
    logic [AW+1:0]    occupancy;

    // A sample requested last cycle will land this cycle, so it already
    // owns a FIFO slot; that keeps pushes from ever hitting a full FIFO.
    assign occupancy      = {1'b0, fifo_count} + {{(AW+1){1'b0}}, pend_q};
    assign out_gen_enable = (state_q == ST_RUN) && !in_stop && (occupancy < OCC_LIMIT);

    assign in_range = ($signed(in_rnd) >= $signed(min_q)) && ($signed(in_rnd) <= $signed(max_q));
    assign push     = pend_q && in_range;
    assign reject   = pend_q && !in_range;
    assign pop      = out_valid && in_ready;

    assign out_gen_reset    = (state_q == ST_SEED);
    assign out_gen_seed     = seed_q;
    assign out_busy         = (state_q != ST_IDLE);
    assign out_cfg_error    = cfg_err_q;
    assign out_reject_count = rej_q;
    assign out_valid        = !fifo_empty;

    always_comb begin
        state_d    = state_q;
        seed_cnt_d = seed_cnt_q;
        min_d      = min_q;
        max_d      = max_q;
        seed_d     = seed_q;
        cfg_err_d  = cfg_err_q;
        rej_d      = rej_q;
        if (reject && (rej_q != 8'hFF))
            rej_d = rej_q + 8'd1;
        unique case (state_q)
            ST_IDLE: begin
                if (in_start) begin
                    if ($signed(in_min) > $signed(in_max)) begin
                        cfg_err_d = 1'b1;
                    end else begin
                        cfg_err_d  = 1'b0;
                        rej_d      = '0;
                        min_d      = in_min;
                        max_d      = in_max;
                        seed_d     = in_seed;
                        seed_cnt_d = '0;
                        state_d    = ST_SEED;
                    end
                end
            end
            ST_SEED: begin
                if (seed_cnt_q == SEED_LAST) begin
                    seed_cnt_d = '0;
                    state_d    = ST_RUN;
                end else begin
                    seed_cnt_d = seed_cnt_q + CW'(1);
                end
            end
            ST_RUN: begin
                if (in_stop)
                    state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (!pend_q)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge in_clock) begin
        if (in_reset) begin
            state_q    <= ST_IDLE;
            seed_cnt_q <= '0;
            min_q      <= '0;
            max_q      <= '0;
            seed_q     <= '0;
            cfg_err_q  <= 1'b0;
            rej_q      <= '0;
            pend_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            seed_cnt_q <= seed_cnt_d;
            min_q      <= min_d;
            max_q      <= max_d;
            seed_q     <= seed_d;
            cfg_err_q  <= cfg_err_d;
            rej_q      <= rej_d;
            pend_q     <= out_gen_enable;
        end
    end

    always_ff @(posedge in_clock) begin
        if (!in_reset)
            assert (!(push && fifo_full));
    end

    rnd_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (in_clock),
        .rst_i   (in_reset),
        .push_i  (push),
        .wdata_i (in_rnd),
        .pop_i   (pop),
        .rdata_o (out_data),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

endmodule

// File: tb/tb_rnd_sample_buffer.sv
// Directed bench for rnd_sample_buffer (WIDTH=8, DEPTH=4, SEED_CYCLES=2).
// The generator is modelled by tick(): after every enable cycle the next
// value of the current sample table appears on in_rnd.
module tb_rnd_sample_buffer;

    logic       in_clock = 1'b0;
    logic       in_reset, in_start, in_stop, in_ready;
    logic [7:0] in_seed, in_min, in_max, in_rnd;
    logic       out_gen_reset, out_gen_enable, out_valid, out_busy, out_cfg_error;
    logic [7:0] out_gen_seed, out_data, out_reject_count;

    int         errors = 0;
    int         checks = 0;
    int         en_cnt = 0;
    int         idx    = 0;
    logic [7:0] cur[$];
    logic [7:0] got_q[$];

    rnd_sample_buffer #(.WIDTH(8), .DEPTH(4), .SEED_CYCLES(2)) dut (
        .in_clock(in_clock), .in_reset(in_reset), .in_start(in_start), .in_stop(in_stop),
        .in_seed(in_seed), .in_min(in_min), .in_max(in_max),
        .out_gen_reset(out_gen_reset), .out_gen_enable(out_gen_enable), .out_gen_seed(out_gen_seed),
        .in_rnd(in_rnd), .out_valid(out_valid), .out_data(out_data), .in_ready(in_ready),
        .out_busy(out_busy), .out_cfg_error(out_cfg_error), .out_reject_count(out_reject_count)
    );

    always #5 in_clock = ~in_clock;

    // One clock cycle; returns 1 time unit after the rising edge.
    task automatic tick();
        logic en;
        @(negedge in_clock);
        en = out_gen_enable && !in_reset;
        if (en) en_cnt++;
        if (out_valid && in_ready && !in_reset) got_q.push_back(out_data);
        @(posedge in_clock);
        #1;
        if (en) begin
            in_rnd = cur[idx % cur.size()];
            idx++;
        end
    endtask

    task automatic do_reset();
        in_reset = 1'b1;
        tick();
        tick();
        in_reset = 1'b0;
        en_cnt = 0;
        idx = 0;
        got_q.delete();
    endtask

    task automatic begin_run(input logic [7:0] lo, input logic [7:0] hi, input logic [7:0] seed);
        in_min = lo; in_max = hi; in_seed = seed;
        in_start = 1'b1;
        tick();
        in_start = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_reset();
        in_reset = 1'b1; in_start = 0; in_stop = 0; in_ready = 0;
        in_seed = 8'h00; in_min = 8'h00; in_max = 8'h00; in_rnd = 8'h00;
        cur = '{8'h00};
        tick(); tick();
        in_reset = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b want=0", out_valid); end
        checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_data got=%h want=00", out_data); end
        checks++; if (out_gen_reset !== 1'b0) begin errors++; $display("FAIL reset_gen_reset got=%b want=0", out_gen_reset); end
        checks++; if (out_gen_enable !== 1'b0) begin errors++; $display("FAIL reset_gen_enable got=%b want=0", out_gen_enable); end
        checks++; if (out_gen_seed !== 8'h00) begin errors++; $display("FAIL reset_gen_seed got=%h want=00", out_gen_seed); end
        checks++; if (out_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", out_busy); end
        checks++; if (out_cfg_error !== 1'b0) begin errors++; $display("FAIL reset_cfg_error got=%b want=0", out_cfg_error); end
        checks++; if (out_reject_count !== 8'h00) begin errors++; $display("FAIL reset_reject got=%0d want=0", out_reject_count); end
    endtask

    // Range [-20, 2]: accepted -20, 2, 0, -5, 2 out of each 10-sample pass.
    task automatic test_range();
        logic [7:0] want[$];
        do_reset();
        cur  = '{8'h05, 8'hEC, 8'h02, 8'h03, 8'hEB, 8'h00, 8'h7F, 8'h80, 8'hFB, 8'h02};
        want = '{8'hEC, 8'h02, 8'h00, 8'hFB, 8'h02, 8'hEC, 8'h02, 8'h00, 8'hFB, 8'h02};
        in_ready = 1'b1;
        in_min = 8'hEC; in_max = 8'h02; in_seed = 8'h02;
        in_start = 1'b1;
        tick();
        in_start = 1'b0;
        checks++; if (out_gen_reset !== 1'b1) begin errors++; $display("FAIL range_seed1_gen_reset got=%b want=1", out_gen_reset); end
        checks++; if (out_gen_seed !== 8'h02) begin errors++; $display("FAIL range_gen_seed got=%h want=02", out_gen_seed); end
        tick();
        checks++; if (out_gen_reset !== 1'b1 || out_gen_enable !== 1'b0) begin errors++; $display("FAIL range_seed2 got rst=%b en=%b want rst=1 en=0", out_gen_reset, out_gen_enable); end
        tick();
        checks++; if (out_gen_reset !== 1'b0 || out_gen_enable !== 1'b1) begin errors++; $display("FAIL range_run_start got rst=%b en=%b want rst=0 en=1", out_gen_reset, out_gen_enable); end
        repeat (20) tick();
        checks++; if (en_cnt !== 20) begin errors++; $display("FAIL range_throughput got=%0d want=20", en_cnt); end
        in_stop = 1'b1;
        tick();
        checks++; if (out_busy !== 1'b1 || out_gen_enable !== 1'b0) begin errors++; $display("FAIL range_drain got busy=%b en=%b want busy=1 en=0", out_busy, out_gen_enable); end
        in_stop = 1'b0;
        tick();
        checks++; if (out_busy !== 1'b0) begin errors++; $display("FAIL range_idle got=%b want=0", out_busy); end
        repeat (4) tick();
        checks++; if (got_q.size() != 10) begin errors++; $display("FAIL range_accepted got=%0d want=10", got_q.size()); end
        for (int i = 0; i < want.size(); i++) begin
            checks++; if (got_q[i] !== want[i]) begin errors++; $display("FAIL range_data[%0d] got=%h want=%h", i, got_q[i], want[i]); end
        end
        checks++; if (out_reject_count !== 8'd10) begin errors++; $display("FAIL range_rejects got=%0d want=10", out_reject_count); end
        checks++; if (got_q.size() + int'(out_reject_count) != en_cnt) begin errors++; $display("FAIL range_sum got=%0d want=%0d", got_q.size() + int'(out_reject_count), en_cnt); end
    endtask

    task automatic test_backpressure();
        logic [7:0] want[$];
        do_reset();
        cur  = '{8'd11, 8'd22, 8'd33, 8'd44, 8'd55, 8'd66};
        want = '{8'd11, 8'd22, 8'd33, 8'd44, 8'd55};
        in_ready = 1'b0;
        begin_run(8'h80, 8'h7F, 8'h10);
        repeat (10) tick();
        checks++; if (en_cnt !== 4) begin errors++; $display("FAIL bp_fill_enables got=%0d want=4", en_cnt); end
        checks++; if (out_gen_enable !== 1'b0) begin errors++; $display("FAIL bp_enable_held got=%b want=0", out_gen_enable); end
        checks++; if (out_valid !== 1'b1 || out_data !== 8'd11) begin errors++; $display("FAIL bp_head got v=%b d=%0d want v=1 d=11", out_valid, out_data); end
        in_ready = 1'b1;
        tick();
        in_ready = 1'b0;
        repeat (5) tick();
        checks++; if (en_cnt !== 5) begin errors++; $display("FAIL bp_refill_enables got=%0d want=5", en_cnt); end
        checks++; if (got_q.size() != 1) begin errors++; $display("FAIL bp_one_pop got=%0d want=1", got_q.size()); end
        checks++; if (out_data !== 8'd22) begin errors++; $display("FAIL bp_next_head got=%0d want=22", out_data); end
        in_stop = 1'b1;
        tick();
        in_stop = 1'b0;
        tick();
        in_ready = 1'b1;
        repeat (6) tick();
        checks++; if (got_q.size() != 5) begin errors++; $display("FAIL bp_total got=%0d want=5", got_q.size()); end
        for (int i = 0; i < want.size(); i++) begin
            checks++; if (got_q[i] !== want[i]) begin errors++; $display("FAIL bp_data[%0d] got=%0d want=%0d", i, got_q[i], want[i]); end
        end
    endtask

    // Range [20, 26]: 20 and 26 accepted (inclusive bounds), 4 of 6 rejected.
    task automatic test_saturate();
        logic [7:0] prev;
        bit         wrapped;
        int         bad;
        do_reset();
        cur = '{8'd19, 8'd20, 8'd27, 8'd26, 8'h80, 8'h7F};
        in_ready = 1'b1;
        begin_run(8'd20, 8'd26, 8'h5A);
        prev = 8'd0;
        wrapped = 1'b0;
        repeat (420) begin
            tick();
            if (out_reject_count < prev) wrapped = 1'b1;
            prev = out_reject_count;
        end
        in_stop = 1'b1;
        tick();
        in_stop = 1'b0;
        repeat (5) tick();
        checks++; if (en_cnt !== 420) begin errors++; $display("FAIL sat_enables got=%0d want=420", en_cnt); end
        checks++; if (out_reject_count !== 8'd255) begin errors++; $display("FAIL sat_count got=%0d want=255", out_reject_count); end
        checks++; if (wrapped !== 1'b0) begin errors++; $display("FAIL sat_wrap got=%b want=0", wrapped); end
        checks++; if (got_q.size() != 140) begin errors++; $display("FAIL sat_accepted got=%0d want=140", got_q.size()); end
        bad = 0;
        for (int i = 0; i < got_q.size(); i++)
            if (got_q[i] !== ((i % 2 == 0) ? 8'd20 : 8'd26)) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL sat_bounds got=%0d bad entries want=0", bad); end
    endtask

    // Runs straight after test_saturate: reject count is 255, seed 5A.
    task automatic test_cfg_error();
        bit rst_seen;
        in_min = 8'd5; in_max = 8'hFB; in_seed = 8'h33;
        in_start = 1'b1;
        tick();
        in_start = 1'b0;
        checks++; if (out_cfg_error !== 1'b1) begin errors++; $display("FAIL cfg_error got=%b want=1", out_cfg_error); end
        checks++; if (out_busy !== 1'b0) begin errors++; $display("FAIL cfg_busy got=%b want=0", out_busy); end
        checks++; if (out_gen_seed !== 8'h5A) begin errors++; $display("FAIL cfg_seed_kept got=%h want=5a", out_gen_seed); end
        checks++; if (out_reject_count !== 8'd255) begin errors++; $display("FAIL cfg_rej_kept got=%0d want=255", out_reject_count); end
        rst_seen = out_gen_reset;
        repeat (4) begin
            tick();
            if (out_gen_reset) rst_seen = 1'b1;
        end
        checks++; if (rst_seen !== 1'b0) begin errors++; $display("FAIL cfg_gen_reset got=%b want=0", rst_seen); end
        // a valid start clears the error and the reject count; stop during SEED is ignored
        in_min = 8'hFF; in_max = 8'h01;
        in_start = 1'b1;
        tick();
        in_start = 1'b0;
        checks++; if (out_cfg_error !== 1'b0 || out_reject_count !== 8'd0) begin errors++; $display("FAIL cfg_clear got err=%b rej=%0d want err=0 rej=0", out_cfg_error, out_reject_count); end
        checks++; if (out_gen_seed !== 8'h33) begin errors++; $display("FAIL cfg_new_seed got=%h want=33", out_gen_seed); end
        in_stop = 1'b1;
        tick();
        in_stop = 1'b0;
        tick();
        checks++; if (out_busy !== 1'b1 || out_gen_enable !== 1'b1) begin errors++; $display("FAIL cfg_stop_in_seed got busy=%b en=%b want 1 1", out_busy, out_gen_enable); end
        in_stop = 1'b1;
        tick();
        in_stop = 1'b0;
        repeat (3) tick();
    endtask

    task automatic test_stop();
        do_reset();
        cur = '{8'd7, 8'd8, 8'd9};
        in_ready = 1'b0;
        begin_run(8'h80, 8'h7F, 8'h01);
        tick();
        in_stop = 1'b1;
        tick();
        checks++; if (out_busy !== 1'b1 || out_gen_enable !== 1'b0) begin errors++; $display("FAIL stop_drain got busy=%b en=%b want 1 0", out_busy, out_gen_enable); end
        checks++; if (out_valid !== 1'b1 || out_data !== 8'd7) begin errors++; $display("FAIL stop_pending got v=%b d=%0d want v=1 d=7", out_valid, out_data); end
        in_stop = 1'b0;
        tick();
        checks++; if (out_busy !== 1'b0) begin errors++; $display("FAIL stop_idle got=%b want=0", out_busy); end
        repeat (3) tick();
        checks++; if (out_valid !== 1'b1 || out_data !== 8'd7) begin errors++; $display("FAIL stop_kept got v=%b d=%0d want v=1 d=7", out_valid, out_data); end
        checks++; if (en_cnt !== 1) begin errors++; $display("FAIL stop_enables got=%0d want=1", en_cnt); end
        in_ready = 1'b1;
        tick();
        in_ready = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stop_emptied got=%b want=0", out_valid); end
        checks++; if (got_q.size() != 1 || got_q[0] !== 8'd7) begin errors++; $display("FAIL stop_read got n=%0d d=%0d want n=1 d=7", got_q.size(), got_q[0]); end
    endtask

    task automatic test_reset_mid_run();
        do_reset();
        cur = '{8'd1, 8'd2, 8'd3, 8'd4};
        in_ready = 1'b0;
        begin_run(8'h80, 8'h7F, 8'h44);
        repeat (4) tick();
        checks++; if (out_valid !== 1'b1 || out_data !== 8'd1) begin errors++; $display("FAIL rmr_before got v=%b d=%0d want v=1 d=1", out_valid, out_data); end
        in_reset = 1'b1;
        tick();
        in_reset = 1'b0;
        checks++; if (out_valid !== 1'b0 || out_data !== 8'd0) begin errors++; $display("FAIL rmr_fifo got v=%b d=%0d want 0 0", out_valid, out_data); end
        checks++; if (out_busy !== 1'b0 || out_gen_enable !== 1'b0 || out_gen_reset !== 1'b0) begin errors++; $display("FAIL rmr_ctrl got busy=%b en=%b rst=%b want 0 0 0", out_busy, out_gen_enable, out_gen_reset); end
        checks++; if (out_gen_seed !== 8'd0 || out_cfg_error !== 1'b0 || out_reject_count !== 8'd0) begin errors++; $display("FAIL rmr_regs got seed=%h err=%b rej=%0d want 0 0 0", out_gen_seed, out_cfg_error, out_reject_count); end
        repeat (3) tick();
        checks++; if (out_valid !== 1'b0 || en_cnt !== 4) begin errors++; $display("FAIL rmr_after got v=%b en=%0d want v=0 en=4", out_valid, en_cnt); end
    endtask

    initial begin
        test_reset();
        test_range();
        test_backpressure();
        test_saturate();
        test_cfg_error();
        test_stop();
        test_reset_mid_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
